// File: rtl/fwd_pkg.sv
// Shared constants and helpers for the forwarding / hazard unit.
package fwd_pkg;

  localparam int REG_IDX_W   = 5;
  localparam int NUM_REGS    = 1 << REG_IDX_W;
  localparam int STG_EX      = 0;
  localparam int STG_MEM     = 1;
  localparam int STG_WB      = 2;
  localparam int STALL_CNT_W = 8;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;

  // One-hot mask selecting a register in the scoreboard vector.
  function automatic logic [NUM_REGS-1:0] reg_mask(input reg_idx_t idx);
    return NUM_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/fwd_port_sel.sv
// Priority bypass selector for one source-operand port. The youngest
// (lowest-index) stage writing the operand wins; if it has no result yet the
// port is hazarded and older stages are never consulted.
module fwd_port_sel
  import fwd_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NSTG = 3
) (
  input  logic [REG_IDX_W-1:0]      rs,
  input  logic                      rs_use,
  input  logic [NSTG*REG_IDX_W-1:0] stg_rd,
  input  logic [NSTG-1:0]           stg_wen,
  input  logic [NSTG-1:0]           stg_rdy,
  input  logic [NSTG*XLEN-1:0]      stg_dat,
  output logic                      fwd_en,
  output logic [XLEN-1:0]           fwd_dat,
  output logic                      hazard
);

  // Scan oldest to youngest so the youngest match overwrites the others.
  always_comb begin
    fwd_en  = 1'b0;
    fwd_dat = '0;
    hazard  = 1'b0;
    if (rs_use && rs != ZERO_REG) begin
      for (int s = NSTG - 1; s >= STG_EX; s--) begin
        if (stg_wen[s] && stg_rd[s*REG_IDX_W +: REG_IDX_W] == rs) begin
          fwd_en  = stg_rdy[s];
          fwd_dat = stg_rdy[s] ? stg_dat[s*XLEN +: XLEN] : '0;
          hazard  = !stg_rdy[s];
        end
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit: per-port bypass selection, long-latency
// register scoreboard, saturating stall counter and sticky timeout flag.
// Optional build macro FWD_PERF_CNT_EN adds free-running performance counters
// (perf_stall_o, perf_fwd_o) that only reset clears.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NRS       = 2,
  parameter int NSTG      = 3,
  parameter int STALL_MAX = 255
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NRS*REG_IDX_W-1:0]  rs_i,
  input  logic [NRS-1:0]            rs_use_i,
  input  logic [NSTG*REG_IDX_W-1:0] stg_rd_i,
  input  logic [NSTG-1:0]           stg_wen_i,
  input  logic [NSTG-1:0]           stg_rdy_i,
  input  logic [NSTG*XLEN-1:0]      stg_dat_i,
  input  logic                      ll_issue_i,
  input  logic [REG_IDX_W-1:0]      ll_issue_rd_i,
  input  logic                      ll_done_i,
  input  logic [REG_IDX_W-1:0]      ll_done_rd_i,
  input  logic                      flush_i,
  output logic [NRS-1:0]            fwd_en_o,
  output logic [NRS*XLEN-1:0]       fwd_dat_o,
  output logic                      stall_o,
  output logic [STALL_CNT_W-1:0]    stall_cnt_o,
  output logic                      timeout_o
`ifdef FWD_PERF_CNT_EN
  ,
  output logic [31:0]               perf_stall_o,
  output logic [31:0]               perf_fwd_o
`endif
);

  localparam logic [STALL_CNT_W-1:0] CNT_MAX = STALL_CNT_W'(STALL_MAX);

  // Increment that sticks at the counter ceiling.
  function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + STALL_CNT_W'(1);
  endfunction

  logic [NUM_REGS-1:0]    pending;
  logic [NUM_REGS-1:0]    pending_nxt;
  logic [NRS-1:0]         stg_haz;
  logic [NRS-1:0]         port_haz;
  logic [STALL_CNT_W-1:0] cnt_inc;

  for (genvar k = 0; k < NRS; k++) begin : g_port
    logic [REG_IDX_W-1:0] rs_k;
    assign rs_k = rs_i[k*REG_IDX_W +: REG_IDX_W];

    fwd_port_sel #(
      .XLEN (XLEN),
      .NSTG (NSTG)
    ) u_sel (
      .rs      (rs_k),
      .rs_use  (rs_use_i[k]),
      .stg_rd  (stg_rd_i),
      .stg_wen (stg_wen_i),
      .stg_rdy (stg_rdy_i),
      .stg_dat (stg_dat_i),
      .fwd_en  (fwd_en_o[k]),
      .fwd_dat (fwd_dat_o[k*XLEN +: XLEN]),
      .hazard  (stg_haz[k])
    );

    // A pending long-latency write only matters when no ready bypass covers it.
    assign port_haz[k] = stg_haz[k]
                       | (rs_use_i[k] & (rs_k != ZERO_REG) & pending[rs_k] & ~fwd_en_o[k]);
  end

  assign stall_o = |port_haz;
  assign cnt_inc = sat_inc(stall_cnt_o);

  // Scoreboard update: clear on completion, then set on issue so issue wins.
  always_comb begin
    pending_nxt = pending;
    if (flush_i) begin
      pending_nxt = '0;
    end else begin
      if (ll_done_i)  pending_nxt = pending_nxt & ~reg_mask(ll_done_rd_i);
      if (ll_issue_i) pending_nxt = pending_nxt | reg_mask(ll_issue_rd_i);
      pending_nxt[0] = 1'b0;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) pending <= '0;
    else         pending <= pending_nxt;
  end

  // Consecutive-stall counter and sticky timeout; flush overrides both.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_o <= '0;
      timeout_o   <= 1'b0;
    end else if (flush_i) begin
      stall_cnt_o <= '0;
      timeout_o   <= 1'b0;
    end else if (stall_o) begin
      stall_cnt_o <= cnt_inc;
      timeout_o   <= timeout_o | (cnt_inc == CNT_MAX);
    end else begin
      stall_cnt_o <= '0;
    end
  end

`ifdef FWD_PERF_CNT_EN
  // Wrapping performance counters, untouched by flush.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_stall_o <= '0;
      perf_fwd_o   <= '0;
    end else begin
      perf_stall_o <= perf_stall_o + 32'(stall_o);
      perf_fwd_o   <= perf_fwd_o + 32'((|fwd_en_o) & ~stall_o);
    end
  end
`endif

endmodule
